usb_rx_pkt_sequencer: RTL

- Receive-side packet controller sitting directly after the bit unstuffer in the USB 2.0 receive path.
- Clears the unstuffer at packet boundaries and consumes only qualified (non-stuffed) bits.
- Hunts SYNC, checks the PID, sequences token, data and handshake fields, and assembles bytes.
- Reports packet completion or error to the protocol layer.

---
 rtl/usb_rx_pkt_sequencer.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_pkt_sequencer.sv
// USB 2.0 receive packet sequencer: hunts SYNC after the bit unstuffer, checks and routes the PID,
// captures token fields, assembles data bytes and reports clean EOP or a coded error.
module usb_rx_pkt_sequencer #(
   parameter int SYNC_MAX  = 32,
   parameter int MAX_BYTES = 1026
) (
   input  logic       gclk,
   input  logic       reset,
   input  logic       rx_active,
   input  logic       bit_stb,
   input  logic       rx_bit,
   input  logic       rx_halt,
   input  logic       stuff_err,
   input  logic       se0,
   output logic       unstuff_clr_l,
   output logic [3:0] pid,
   output logic       pid_valid,
   output logic [6:0] dev_addr,
   output logic [3:0] endp,
   output logic [4:0] crc5,
   output logic       token_valid,
   output logic [7:0] data_byte,
   output logic       data_valid,
   output logic       pkt_done,
   output logic       err_valid,
   output logic [2:0] err_code
);

   localparam int BIT_W  = ($clog2(SYNC_MAX + 1) > 5) ? $clog2(SYNC_MAX + 1) : 5;
   localparam int BYTE_W = $clog2(MAX_BYTES + 1);

   localparam logic [2:0] ERR_PID    = 3'd1;
   localparam logic [2:0] ERR_STUFF  = 3'd2;
   localparam logic [2:0] ERR_EOP    = 3'd3;
   localparam logic [2:0] ERR_ACTIVE = 3'd4;
   localparam logic [2:0] ERR_SYNC   = 3'd5;
   localparam logic [2:0] ERR_OVF    = 3'd6;
   localparam logic [2:0] ERR_UNSUP  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SYNC  = 3'd1,
      S_PID   = 3'd2,
      S_TOKEN = 3'd3,
      S_DATA  = 3'd4,
      S_HSK   = 3'd5,
      S_EOP   = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         sh_q, sh_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic                unstuff_clr_l_q, unstuff_clr_l_d;
   logic [3:0]          pid_q, pid_d;
   logic                pid_valid_q, pid_valid_d;
   logic [6:0]          dev_addr_q, dev_addr_d;
   logic [3:0]          endp_q, endp_d;
   logic [4:0]          crc5_q, crc5_d;
   logic                token_valid_q, token_valid_d;
   logic [7:0]          data_byte_q, data_byte_d;
   logic                data_valid_q, data_valid_d;
   logic                pkt_done_q, pkt_done_d;
   logic                err_valid_q, err_valid_d;
   logic [2:0]          err_code_q, err_code_d;

   logic                q_s;
   logic [15:0]         sh_shift_s;
   logic [7:0]          sh8_s;
   logic                pid_ok_s;
   logic                err_hit_s;
   logic [2:0]          err_sel_s;

   // The low byte of the 16-bit shifter only matters for token capture; sh8_s is the last 8 wire bits.
   assign q_s        = bit_stb & ~rx_halt;
   assign sh_shift_s = {rx_bit, sh_q[15:1]};
   assign sh8_s      = sh_shift_s[15:8];
   assign pid_ok_s   = (sh8_s[7:4] == ~sh8_s[3:0]);

   // Next-state, field capture and output pulse logic.
   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      byte_cnt_d      = byte_cnt_q;
      unstuff_clr_l_d = 1'b1;
      pid_d           = pid_q;
      pid_valid_d     = 1'b0;
      dev_addr_d      = dev_addr_q;
      endp_d          = endp_q;
      crc5_d          = crc5_q;
      token_valid_d   = 1'b0;
      data_byte_d     = data_byte_q;
      data_valid_d    = 1'b0;
      pkt_done_d      = 1'b0;
      err_valid_d     = 1'b0;
      err_code_d      = err_code_q;
      err_hit_s       = 1'b0;
      err_sel_s       = 3'd0;
      if (q_s) begin
         sh_d = sh_shift_s;
      end else begin
         sh_d = sh_q;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_active) begin
               state_d         = S_SYNC;
               unstuff_clr_l_d = 1'b0;
               sh_d            = 16'h0000;
               bit_cnt_d       = '0;
               byte_cnt_d      = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SYNC: begin
            if (!rx_active) begin
               state_d = S_IDLE;
            end else if (q_s) begin
               if (sh8_s == 8'h80) begin
                  state_d   = S_PID;
                  bit_cnt_d = '0;
               end else if (bit_cnt_q == BIT_W'(SYNC_MAX - 1)) begin
                  err_hit_s = 1'b1;
                  err_sel_s = ERR_SYNC;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               state_d = S_SYNC;
            end
         end
         S_PID, S_TOKEN, S_DATA, S_HSK: begin
            if (bit_stb && stuff_err) begin
               err_hit_s = 1'b1;
               err_sel_s = ERR_STUFF;
            end else if (!rx_active) begin
               err_hit_s = 1'b1;
               err_sel_s = ERR_ACTIVE;
            end else if (bit_stb && se0) begin
               // EOP is legal only on a byte boundary of a data packet or after a token/handshake.
               if ((state_q == S_HSK) || ((state_q == S_DATA) && (bit_cnt_q == BIT_W'(0)))) begin
                  state_d    = S_EOP;
                  pkt_done_d = 1'b1;
               end else begin
                  err_hit_s = 1'b1;
                  err_sel_s = ERR_EOP;
               end
            end else if (q_s) begin
               case (state_q)
                  S_PID: begin
                     if (bit_cnt_q == BIT_W'(7)) begin
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        if (!pid_ok_s) begin
                           err_hit_s = 1'b1;
                           err_sel_s = ERR_PID;
                        end else begin
                           pid_d       = sh8_s[3:0];
                           pid_valid_d = 1'b1;
                           case (sh8_s[3:0])
                              4'b0001, 4'b1001, 4'b0101, 4'b1101, 4'b0100: state_d = S_TOKEN;
                              4'b0011, 4'b1011, 4'b0111, 4'b1111:          state_d = S_DATA;
                              4'b0010, 4'b1010, 4'b1110, 4'b0110:          state_d = S_HSK;
                              default: begin
                                 err_hit_s = 1'b1;
                                 err_sel_s = ERR_UNSUP;
                              end
                           endcase
                        end
                     end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     end
                  end
                  S_TOKEN: begin
                     if (bit_cnt_q == BIT_W'(15)) begin
                        bit_cnt_d     = '0;
                        dev_addr_d    = sh_shift_s[6:0];
                        endp_d        = sh_shift_s[10:7];
                        crc5_d        = sh_shift_s[15:11];
                        token_valid_d = 1'b1;
                        state_d       = S_HSK;
                     end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     end
                  end
                  S_DATA: begin
                     if (bit_cnt_q == BIT_W'(7)) begin
                        bit_cnt_d = '0;
                        if (byte_cnt_q == BYTE_W'(MAX_BYTES)) begin
                           err_hit_s = 1'b1;
                           err_sel_s = ERR_OVF;
                        end else begin
                           data_byte_d  = sh8_s;
                           data_valid_d = 1'b1;
                           byte_cnt_d   = byte_cnt_q + BYTE_W'(1);
                        end
                     end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     end
                  end
                  default: begin
                     err_hit_s = 1'b1;
                     err_sel_s = ERR_EOP;
                  end
               endcase
            end else begin
               state_d = state_q;
            end
         end
         S_EOP, S_ERR: begin
            if (!rx_active) begin
               state_d         = S_IDLE;
               unstuff_clr_l_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Errors override whatever the state logic wanted to emit on this strobe.
      if (err_hit_s) begin
         state_d       = S_ERR;
         err_valid_d   = 1'b1;
         err_code_d    = err_sel_s;
         data_valid_d  = 1'b0;
         token_valid_d = 1'b0;
         data_byte_d   = data_byte_q;
      end else begin
         err_code_d = err_code_q;
      end
   end

   // State and output registers.
   always_ff @(posedge gclk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         sh_q            <= 16'h0000;
         bit_cnt_q       <= '0;
         byte_cnt_q      <= '0;
         unstuff_clr_l_q <= 1'b1;
         pid_q           <= 4'h0;
         pid_valid_q     <= 1'b0;
         dev_addr_q      <= 7'h00;
         endp_q          <= 4'h0;
         crc5_q          <= 5'h00;
         token_valid_q   <= 1'b0;
         data_byte_q     <= 8'h00;
         data_valid_q    <= 1'b0;
         pkt_done_q      <= 1'b0;
         err_valid_q     <= 1'b0;
         err_code_q      <= 3'd0;
      end else begin
         state_q         <= state_d;
         sh_q            <= sh_d;
         bit_cnt_q       <= bit_cnt_d;
         byte_cnt_q      <= byte_cnt_d;
         unstuff_clr_l_q <= unstuff_clr_l_d;
         pid_q           <= pid_d;
         pid_valid_q     <= pid_valid_d;
         dev_addr_q      <= dev_addr_d;
         endp_q          <= endp_d;
         crc5_q          <= crc5_d;
         token_valid_q   <= token_valid_d;
         data_byte_q     <= data_byte_d;
         data_valid_q    <= data_valid_d;
         pkt_done_q      <= pkt_done_d;
         err_valid_q     <= err_valid_d;
         err_code_q      <= err_code_d;
      end
   end

   assign unstuff_clr_l = unstuff_clr_l_q;
   assign pid           = pid_q;
   assign pid_valid     = pid_valid_q;
   assign dev_addr      = dev_addr_q;
   assign endp          = endp_q;
   assign crc5          = crc5_q;
   assign token_valid   = token_valid_q;
   assign data_byte     = data_byte_q;
   assign data_valid    = data_valid_q;
   assign pkt_done      = pkt_done_q;
   assign err_valid     = err_valid_q;
   assign err_code      = err_code_q;

endmodule
